// File: rtl/vsm_key_sequencer.sv
// Calculator keypad sequencer: turns edge-detected key presses into one-cycle register strobes.
// All outputs are registered; the strobe for a key event in cycle N appears in cycle N+1.
module vsm_key_sequencer #(
  parameter int unsigned EXEC_LAT = 2
) (
  input  logic       MainClock,
  input  logic       Reset,
  input  logic       KeyStrobe,
  input  logic [1:0] KeyClass,
  output logic       LatchA,
  output logic       LatchB,
  output logic       ClearA,
  output logic       ClearB,
  output logic       LatchOp,
  output logic       LatchRes,
  output logic       Busy,
  output logic       Err,
  output logic [2:0] State
);

  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_OP = 3'd1;
  localparam logic [2:0] WAIT_B  = 3'd2;
  localparam logic [2:0] WAIT_EQ = 3'd3;
  localparam logic [2:0] EXEC    = 3'd4;
  localparam logic [2:0] SHOW    = 3'd5;

  localparam logic [1:0] K_DIGIT = 2'b00;
  localparam logic [1:0] K_OP    = 2'b01;
  localparam logic [1:0] K_EQ    = 2'b10;
  localparam logic [1:0] K_CLR   = 2'b11;

  localparam logic [3:0] LAT = 4'(EXEC_LAT);

  logic       ks_q;
  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       la_q, la_d, lb_q, lb_d, ca_q, ca_d, cb_q, cb_d;
  logic       lo_q, lo_d, lr_q, lr_d, busy_q, busy_d;

  logic key_ev, is_dig, is_op, is_eq, is_clr;

  assign key_ev = KeyStrobe & ~ks_q;
  assign is_dig = key_ev & (KeyClass == K_DIGIT);
  assign is_op  = key_ev & (KeyClass == K_OP);
  assign is_eq  = key_ev & (KeyClass == K_EQ);
  assign is_clr = key_ev & (KeyClass == K_CLR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    la_d    = 1'b0;
    lb_d    = 1'b0;
    ca_d    = 1'b0;
    cb_d    = 1'b0;
    lo_d    = 1'b0;
    lr_d    = 1'b0;
    // Clear wins over everything, including an EXEC countdown about to expire.
    if (is_clr) begin
      ca_d    = 1'b1;
      cb_d    = 1'b1;
      err_d   = 1'b0;
      cnt_d   = 4'd0;
      state_d = WAIT_A;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (is_dig) begin
            la_d    = 1'b1;
            state_d = WAIT_OP;
          end else if (is_op || is_eq) begin
            err_d = 1'b1;
          end
        end
        WAIT_OP: begin
          if (is_op) begin
            lo_d    = 1'b1;
            state_d = WAIT_B;
          end else if (is_dig) begin
            la_d = 1'b1;
          end else if (is_eq) begin
            err_d = 1'b1;
          end
        end
        WAIT_B: begin
          if (is_dig) begin
            lb_d    = 1'b1;
            state_d = WAIT_EQ;
          end else if (is_op) begin
            lo_d = 1'b1;
          end else if (is_eq) begin
            err_d = 1'b1;
          end
        end
        WAIT_EQ: begin
          if (is_eq) begin
            cnt_d   = LAT;
            state_d = EXEC;
          end else if (is_dig) begin
            lb_d = 1'b1;
          end else if (is_op) begin
            err_d = 1'b1;
          end
        end
        EXEC: begin
          if (cnt_q <= 4'd1) begin
            lr_d    = 1'b1;
            cnt_d   = 4'd0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        SHOW: begin
          if (is_dig) begin
            la_d    = 1'b1;
            state_d = WAIT_OP;
          end else if (is_op || is_eq) begin
            err_d = 1'b1;
          end
        end
        default: begin
          cnt_d   = 4'd0;
          state_d = WAIT_A;
        end
      endcase
    end
    busy_d = (state_d == EXEC);
  end

  always_ff @(posedge MainClock) begin
    // The key history keeps tracking through reset so a held key cannot fire on release.
    ks_q <= KeyStrobe;
    if (Reset) begin
      state_q <= WAIT_A;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      la_q    <= 1'b0;
      lb_q    <= 1'b0;
      ca_q    <= 1'b0;
      cb_q    <= 1'b0;
      lo_q    <= 1'b0;
      lr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      lo_q    <= lo_d;
      lr_q    <= lr_d;
      busy_q  <= busy_d;
    end
  end

  assign LatchA   = la_q;
  assign LatchB   = lb_q;
  assign ClearA   = ca_q;
  assign ClearB   = cb_q;
  assign LatchOp  = lo_q;
  assign LatchRes = lr_q;
  assign Busy     = busy_q;
  assign Err      = err_q;
  assign State    = state_q;

endmodule

// File: tb/tb_vsm_key_sequencer.sv
// Directed bench for vsm_key_sequencer: vector table plus hand sequences for reset/abort cases.
module tb_vsm_key_sequencer;

  logic       MainClock = 1'b0;
  logic       Reset;
  logic       KeyStrobe;
  logic [1:0] KeyClass;
  logic       LatchA, LatchB, ClearA, ClearB, LatchOp, LatchRes, Busy, Err;
  logic [2:0] State;

  vsm_key_sequencer #(.EXEC_LAT(2)) dut (
    .MainClock(MainClock), .Reset(Reset), .KeyStrobe(KeyStrobe), .KeyClass(KeyClass),
    .LatchA(LatchA), .LatchB(LatchB), .ClearA(ClearA), .ClearB(ClearB),
    .LatchOp(LatchOp), .LatchRes(LatchRes), .Busy(Busy), .Err(Err), .State(State)
  );

  always #5 MainClock = ~MainClock;

  localparam logic [1:0] D = 2'b00, O = 2'b01, E = 2'b10, C = 2'b11;
  // Strobe vector order: {LatchA, LatchB, ClearA, ClearB, LatchOp, LatchRes}
  localparam logic [5:0] S0 = 6'b000000, LA = 6'b100000, LB = 6'b010000;
  localparam logic [5:0] CL = 6'b001100, LO = 6'b000010, LR = 6'b000001;

  typedef struct {
    logic       ks;
    logic [1:0] kc;
    logic [2:0] st;
    logic [5:0] strb;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tbl[100];
  int   n_vec = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [5:0] strobes();
    return {LatchA, LatchB, ClearA, ClearB, LatchOp, LatchRes};
  endfunction

  task automatic add(input logic ks, input logic [1:0] kc, input logic [2:0] st,
                     input logic [5:0] strb, input logic busy, input logic err);
    tbl[n_vec].ks   = ks;
    tbl[n_vec].kc   = kc;
    tbl[n_vec].st   = st;
    tbl[n_vec].strb = strb;
    tbl[n_vec].busy = busy;
    tbl[n_vec].err  = err;
    n_vec++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [2:0] st, input logic [5:0] strb,
                            input logic busy, input logic err);
    chk({name, ".state"}, int'(State), int'(st));
    chk({name, ".strobes"}, int'(strobes()), int'(strb));
    chk({name, ".busy"}, int'(Busy), int'(busy));
    chk({name, ".err"}, int'(Err), int'(err));
  endtask

  task automatic cyc();
    @(posedge MainClock);
    #1;
  endtask

  task automatic apply(input logic ks, input logic [1:0] kc);
    KeyStrobe = ks;
    KeyClass  = kc;
    cyc();
  endtask

  task automatic press(input logic [1:0] kc);
    apply(1'b1, kc);
    apply(1'b0, kc);
  endtask

  initial begin
    Reset = 1'b1;
    KeyStrobe = 1'b0;
    KeyClass = D;

    // Full operation, 3-cycle presses; equals in cycle N -> EXEC N+1..N+2, result N+3
    for (int i = 0; i < 3; i++) add(1, D, 1, (i == 0) ? LA : S0, 0, 0);
    add(0, D, 1, S0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, O, 2, (i == 0) ? LO : S0, 0, 0);
    add(0, O, 2, S0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, D, 3, (i == 0) ? LB : S0, 0, 0);
    add(0, D, 3, S0, 0, 0);
    add(1, E, 4, S0, 1, 0);
    add(1, E, 4, S0, 1, 0);
    add(1, E, 5, LR, 0, 0);
    add(0, E, 5, S0, 0, 0);
    // From SHOW a digit restarts; op pressed inside EXEC is dropped
    add(1, D, 1, LA, 0, 0); add(0, D, 1, S0, 0, 0);
    add(1, O, 2, LO, 0, 0); add(0, O, 2, S0, 0, 0);
    add(1, D, 3, LB, 0, 0); add(0, D, 3, S0, 0, 0);
    add(1, E, 4, S0, 1, 0); add(0, E, 4, S0, 1, 0);
    add(1, O, 5, LR, 0, 0); add(0, O, 5, S0, 0, 0);
    add(1, C, 0, CL, 0, 0); add(0, C, 0, S0, 0, 0);
    // Error path: sticky across a valid key, cleared only by clear
    add(1, E, 0, S0, 0, 1); add(0, E, 0, S0, 0, 1);
    add(1, O, 0, S0, 0, 1); add(0, O, 0, S0, 0, 1);
    add(1, D, 1, LA, 0, 1); add(0, D, 1, S0, 0, 1);
    add(1, C, 0, CL, 0, 0); add(0, C, 0, S0, 0, 0);
    // Long press: one LatchA only
    for (int i = 0; i < 10; i++) add(1, D, 1, (i == 0) ? LA : S0, 0, 0);
    add(0, D, 1, S0, 0, 0);
    // Overwrites and replacement, errors in WAIT_B / WAIT_EQ
    add(1, D, 1, LA, 0, 0); add(0, D, 1, S0, 0, 0);
    add(1, O, 2, LO, 0, 0); add(0, O, 2, S0, 0, 0);
    add(1, O, 2, LO, 0, 0); add(0, O, 2, S0, 0, 0);
    add(1, E, 2, S0, 0, 1); add(0, E, 2, S0, 0, 1);
    add(1, D, 3, LB, 0, 1); add(0, D, 3, S0, 0, 1);
    add(1, D, 3, LB, 0, 1); add(0, D, 3, S0, 0, 1);
    add(1, O, 3, S0, 0, 1); add(0, O, 3, S0, 0, 1);
    add(1, C, 0, CL, 0, 0); add(0, C, 0, S0, 0, 0);

    cyc();
    cyc();
    expect_out("reset", 3'd0, S0, 1'b0, 1'b0);
    Reset = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      apply(tbl[i].ks, tbl[i].kc);
      expect_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].strb, tbl[i].busy, tbl[i].err);
    end

    // Clear in the earliest EXEC cycle a new key can arrive: beats the expiring countdown
    press(D); press(O); press(D);
    apply(1'b1, E);
    expect_out("abort_enter", 3'd4, S0, 1'b1, 1'b0);
    apply(1'b0, E);
    expect_out("abort_exec2", 3'd4, S0, 1'b1, 1'b0);
    apply(1'b1, C);
    expect_out("abort_clear", 3'd0, CL, 1'b0, 1'b0);
    apply(1'b0, C);
    expect_out("abort_after1", 3'd0, S0, 1'b0, 1'b0);
    apply(1'b0, C);
    expect_out("abort_after2", 3'd0, S0, 1'b0, 1'b0);

    // Reset during EXEC: no LatchRes afterwards
    press(D); press(O); press(D);
    apply(1'b1, E);
    expect_out("rst_exec_enter", 3'd4, S0, 1'b1, 1'b0);
    Reset = 1'b1;
    apply(1'b0, E);
    expect_out("rst_exec_rst", 3'd0, S0, 1'b0, 1'b0);
    Reset = 1'b0;
    apply(1'b0, E);
    expect_out("rst_exec_post1", 3'd0, S0, 1'b0, 1'b0);
    apply(1'b0, E);
    expect_out("rst_exec_post2", 3'd0, S0, 1'b0, 1'b0);

    // Digit held across reset release gives no event until re-pressed
    Reset = 1'b1;
    apply(1'b1, D);
    expect_out("held_rst1", 3'd0, S0, 1'b0, 1'b0);
    apply(1'b1, D);
    expect_out("held_rst2", 3'd0, S0, 1'b0, 1'b0);
    Reset = 1'b0;
    apply(1'b1, D);
    expect_out("held_rel1", 3'd0, S0, 1'b0, 1'b0);
    apply(1'b1, D);
    expect_out("held_rel2", 3'd0, S0, 1'b0, 1'b0);
    apply(1'b0, D);
    expect_out("held_up", 3'd0, S0, 1'b0, 1'b0);
    apply(1'b1, D);
    expect_out("held_repress", 3'd1, LA, 1'b0, 1'b0);
    apply(1'b0, D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
